// File: rtl/dm_responder_if.sv
// Initiator <-> responder access bus for dm_responder.
//   master: initiator side, drives req/we/addr/wdata/be, observes the response.
//   slave : responder side, samples the request, drives rdata/ready/err/busy.
interface dm_responder_if;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW / 8;

    logic          req;
    logic          we;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
    logic [DW-1:0] rdata;
    logic          ready;
    logic          err;
    logic          busy;

    modport master (
        output req, we, addr, wdata, be,
        input  rdata, ready, err, busy
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output rdata, ready, err, busy
    );
endinterface

// File: rtl/dm_responder.sv
// Single-access memory responder with a fixed, parameterised response latency.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - dm_responder_if.slave: req/we/addr/wdata/be in, rdata/ready/err/busy out
// One request is accepted from IDLE, held for WAIT cycles, committed on the edge
// that enters RESP, and answered with a one-cycle ready strobe. The request seen
// at the acceptance edge counts as the first edge, so ready rises WAIT edges later.
module dm_responder #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WAIT  = 2
) (
    input  logic          clk,
    input  logic          rst,
    dm_responder_if.slave bus
);
    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW / 8;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          commit_c;

    logic          we_q;
    logic [DW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [BW-1:0] be_q;

    logic          acc_we;
    logic [DW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata;
    logic [BW-1:0] acc_be;
    logic          acc_bad;
    logic [AW-1:0] acc_idx;

    logic [DW-1:0] rdata_q, rdata_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;

    logic [DW-1:0] mem [DEPTH];

    // State register plus the request latch and wait counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_IDLE && bus.req) begin
                we_q    <= bus.we;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
                be_q    <= bus.be;
            end
        end
    end

    // Next-state and commit decision.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        commit_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    if (WAIT == 0) begin
                        state_d  = S_RESP;
                        commit_c = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CW'(WAIT);
                    end
                end
            end
            S_WAIT: begin
                // cnt_q <= 1 also covers a stray zero so the FSM can never stall
                if (cnt_q <= CW'(1)) begin
                    state_d  = S_RESP;
                    cnt_d    = '0;
                    commit_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // With WAIT=0 the commit happens on the acceptance edge, so use live inputs.
    always_comb begin
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_be    = be_q;
        if (state_q == S_IDLE) begin
            acc_we    = bus.we;
            acc_addr  = bus.addr;
            acc_wdata = bus.wdata;
            acc_be    = bus.be;
        end
        acc_bad = (acc_addr[1:0] != 2'b00) || (acc_addr[DW-1:AW+2] != '0);
        acc_idx = acc_addr[AW+1:2];
    end

    // Next values of the registered response outputs.
    always_comb begin
        ready_d = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        busy_d  = (state_d != S_IDLE);
        if (commit_c) begin
            ready_d = 1'b1;
            err_d   = acc_bad;
            rdata_d = (acc_bad || acc_we) ? '0 : mem[acc_idx];
        end
    end

    // Response output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Storage is not reset; a reset edge must never commit a write.
    always_ff @(posedge clk) begin
        if (rst && commit_c && acc_we && !acc_bad) begin
            for (int i = 0; i < int'(BW); i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.busy  = busy_q;
endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: a WAIT=2/DEPTH=1024 instance and a WAIT=0/DEPTH=16
// instance, checked against a word-array model with a fixed latency rule.
module tb_dm_responder;
    localparam int unsigned DA = 1024;
    localparam int unsigned WA = 2;
    localparam int unsigned DB = 16;
    localparam int unsigned WB = 0;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   n_run;
    int   n_fail;

    logic [31:0] mem_a [int];
    logic [31:0] mem_b [int];

    dm_responder_if bus_a ();
    dm_responder_if bus_b ();

    dm_responder #(.DEPTH(DA), .WAIT(WA)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
    dm_responder #(.DEPTH(DB), .WAIT(WB)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int wait_of(input int sel);
        return (sel == 0) ? int'(WA) : int'(WB);
    endfunction

    function automatic logic is_bad(input int sel, input logic [31:0] a);
        longint depth;
        depth = (sel == 0) ? longint'(DA) : longint'(DB);
        return (a[1:0] != 2'b00) || (longint'(a) >= 4 * depth);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic model_write(input int sel, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] b);
        int idx;
        if (is_bad(sel, a)) return;
        idx = int'(a >> 2);
        if (sel == 0) begin
            if (mem_a.exists(idx)) mem_a[idx] = merge(mem_a[idx], d, b);
            else if (b == 4'hF) mem_a[idx] = d;
        end else begin
            if (mem_b.exists(idx)) mem_b[idx] = merge(mem_b[idx], d, b);
            else if (b == 4'hF) mem_b[idx] = d;
        end
    endtask

    function automatic logic [31:0] model_read(input int sel, input logic [31:0] a);
        int idx;
        idx = int'(a >> 2);
        if (sel == 0) return mem_a.exists(idx) ? mem_a[idx] : 32'h0;
        return mem_b.exists(idx) ? mem_b[idx] : 32'h0;
    endfunction

    task automatic drive(input int sel, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        if (sel == 0) begin
            bus_a.req = r; bus_a.we = w; bus_a.addr = a; bus_a.wdata = d; bus_a.be = b;
        end else begin
            bus_b.req = r; bus_b.we = w; bus_b.addr = a; bus_b.wdata = d; bus_b.be = b;
        end
    endtask

    // {busy, ready, err, rdata}
    function automatic logic [34:0] sample(input int sel);
        if (sel == 0) return {bus_a.busy, bus_a.ready, bus_a.err, bus_a.rdata};
        return {bus_b.busy, bus_b.ready, bus_b.err, bus_b.rdata};
    endfunction

    // One access; observes WAIT+2 cycles from the acceptance edge, reports what it saw.
    task automatic run_xact(input int sel, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] b,
                            output int lat, output int pulses, output logic e,
                            output logic [31:0] rd, output logic [31:0] rd_hold,
                            output int proto_bad);
        int wt;
        logic [34:0] s;
        wt = wait_of(sel);
        lat = -1; pulses = 0; e = 1'b0; rd = '0; rd_hold = '0; proto_bad = 0;
        @(negedge clk);
        drive(sel, 1'b1, w, a, d, b);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, w, a, d, b);
        for (int k = 0; k <= wt + 1; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            s = sample(sel);
            if (s[33] === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat = k; e = s[32]; rd = s[31:0];
                end
            end else if (s[32] !== 1'b0) begin
                proto_bad++;
            end
            if (s[34] !== (k <= wt)) proto_bad++;
            if (k == wt + 1) rd_hold = s[31:0];
        end
    endtask

    task automatic test_reset();
        logic [34:0] s;
        rst_a = 1'b0;
        rst_b = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        for (int sel = 0; sel < 2; sel++) begin
            s = sample(sel);
            n_run++;
            if (s[34:32] !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_flags[%0d]: busy/ready/err=%b want 000", sel, s[34:32]);
            end
            n_run++;
            if (s[31:0] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_rdata[%0d]: got %h want 00000000", sel, s[31:0]);
            end
        end
        @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;
    endtask

    task automatic test_basic();
        int lat, pu, pb;
        logic e;
        logic [31:0] rd, rh;
        run_xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, pu, e, rd, rh, pb);
        model_write(0, 32'h10, 32'hDEADBEEF, 4'hF);
        n_run++;
        if (lat !== int'(WA) || pu !== 1) begin
            n_fail++;
            $display("FAIL basic_wr_latency: ready at %0d (%0d pulses) want %0d (1 pulse)", lat, pu, WA);
        end
        n_run++;
        if (e !== 1'b0 || rd !== 32'h0 || pb !== 0) begin
            n_fail++;
            $display("FAIL basic_wr_resp: err=%b rdata=%h proto=%0d want 0/00000000/0", e, rd, pb);
        end
        run_xact(0, 1'b0, 32'h10, 32'h0, 4'h0, lat, pu, e, rd, rh, pb);
        n_run++;
        if (lat !== int'(WA) || pu !== 1 || pb !== 0) begin
            n_fail++;
            $display("FAIL basic_rd_latency: ready at %0d (%0d pulses, proto %0d) want %0d", lat, pu, pb, WA);
        end
        n_run++;
        if (e !== 1'b0 || rd !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL basic_rd_data: err=%b rdata=%h want 0/deadbeef", e, rd);
        end
        n_run++;
        if (rh !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL basic_rdata_hold: got %h want deadbeef", rh);
        end
    endtask

    task automatic test_partial();
        int lat, pu, pb;
        logic e;
        logic [31:0] rd, rh;
        run_xact(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, lat, pu, e, rd, rh, pb);
        model_write(0, 32'h10, 32'h11223344, 4'b0101);
        n_run++;
        if (e !== 1'b0 || rd !== 32'h0 || lat !== int'(WA)) begin
            n_fail++;
            $display("FAIL partial_wr: err=%b rdata=%h lat=%0d want 0/00000000/%0d", e, rd, lat, WA);
        end
        run_xact(0, 1'b0, 32'h10, 32'h0, 4'hF, lat, pu, e, rd, rh, pb);
        n_run++;
        if (rd !== 32'hDE22BE44 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL partial_rd: rdata=%h err=%b want de22be44/0", rd, e);
        end
    endtask

    task automatic test_errors();
        int lat, pu, pb;
        logic e;
        logic [31:0] rd, rh;
        logic [31:0] addrs [4];
        logic        wes [4];
        addrs[0] = 32'h13;               wes[0] = 1'b0;
        addrs[1] = 32'(4 * DA);          wes[1] = 1'b0;
        addrs[2] = 32'h12;               wes[2] = 1'b1;
        addrs[3] = 32'(4 * DA) + 32'h10; wes[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_xact(0, wes[i], addrs[i], 32'hFFFFFFFF, 4'hF, lat, pu, e, rd, rh, pb);
            n_run++;
            if (lat !== int'(WA) || pu !== 1 || e !== 1'b1 || rd !== 32'h0) begin
                n_fail++;
                $display("FAIL err_resp[%h]: lat=%0d pulses=%0d err=%b rdata=%h want %0d/1/1/00000000",
                         addrs[i], lat, pu, e, rd, WA);
            end
        end
        run_xact(0, 1'b0, 32'h10, 32'h0, 4'h0, lat, pu, e, rd, rh, pb);
        n_run++;
        if (rd !== model_read(0, 32'h10) || e !== 1'b0) begin
            n_fail++;
            $display("FAIL err_no_write: rdata=%h err=%b want %h/0", rd, e, model_read(0, 32'h10));
        end
    endtask

    task automatic test_be_zero();
        int lat, pu, pb;
        logic e;
        logic [31:0] rd, rh;
        run_xact(0, 1'b1, 32'h10, 32'hA5A5A5A5, 4'h0, lat, pu, e, rd, rh, pb);
        n_run++;
        if (lat !== int'(WA) || pu !== 1 || e !== 1'b0 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL be_zero_resp: lat=%0d pulses=%0d err=%b rdata=%h", lat, pu, e, rd);
        end
        run_xact(0, 1'b0, 32'h10, 32'h0, 4'h0, lat, pu, e, rd, rh, pb);
        n_run++;
        if (rd !== model_read(0, 32'h10)) begin
            n_fail++;
            $display("FAIL be_zero_unchanged: rdata=%h want %h", rd, model_read(0, 32'h10));
        end
    endtask

    // req held for 10 edges: ready lands on every (WAIT+2)-th cycle starting at WAIT.
    task automatic test_hold_req(input int sel, input logic [31:0] a);
        int wt, period, exp_p, pulses, rdbad;
        int pos [2];
        logic [34:0] s;
        wt = wait_of(sel);
        period = wt + 2;
        exp_p = 0;
        for (int k = 0; k < 10; k++) if (k % period == wt) exp_p++;
        pulses = 0; rdbad = 0; pos[0] = -1; pos[1] = -1;
        @(negedge clk);
        drive(sel, 1'b1, 1'b0, a, 32'h0, 4'h0);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            s = sample(sel);
            if (s[33] === 1'b1) begin
                if (pulses < 2) pos[pulses] = k;
                pulses++;
                if (s[31:0] !== model_read(sel, a)) rdbad++;
            end
        end
        drive(sel, 1'b0, 1'b0, a, 32'h0, 4'h0);
        repeat (wt + 3) @(posedge clk);
        #1;
        n_run++;
        if (pulses !== exp_p) begin
            n_fail++;
            $display("FAIL hold_pulses[%0d]: got %0d want %0d", sel, pulses, exp_p);
        end
        n_run++;
        if (pos[0] !== wt || pos[1] - pos[0] !== period) begin
            n_fail++;
            $display("FAIL hold_spacing[%0d]: first=%0d gap=%0d want %0d/%0d",
                     sel, pos[0], pos[1] - pos[0], wt, period);
        end
        n_run++;
        if (rdbad !== 0) begin
            n_fail++;
            $display("FAIL hold_rdata[%0d]: %0d wrong words want 0", sel, rdbad);
        end
    endtask

    task automatic test_wait0();
        int lat, pu, pb;
        logic e;
        logic [31:0] rd, rh;
        run_xact(1, 1'b1, 32'h8, 32'hCAFEF00D, 4'hF, lat, pu, e, rd, rh, pb);
        model_write(1, 32'h8, 32'hCAFEF00D, 4'hF);
        n_run++;
        if (lat !== 0 || pu !== 1 || pb !== 0 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL wait0_wr: lat=%0d pulses=%0d proto=%0d err=%b want 0/1/0/0", lat, pu, pb, e);
        end
        for (int i = 0; i < 3; i++) begin
            run_xact(1, 1'b0, 32'h8, 32'h0, 4'h0, lat, pu, e, rd, rh, pb);
            n_run++;
            if (lat !== 0 || rd !== 32'hCAFEF00D || pb !== 0) begin
                n_fail++;
                $display("FAIL wait0_rd[%0d]: lat=%0d rdata=%h proto=%0d want 0/cafef00d/0", i, lat, rd, pb);
            end
        end
        test_hold_req(1, 32'h8);
    endtask

    task automatic test_random(input int sel, input int nops);
        int lat, pu, pb, depth, bad_cnt;
        logic e, w, xe;
        logic [31:0] rd, rh, a, d, xr;
        logic [3:0] b;
        logic [31:0] pool [16];
        depth = (sel == 0) ? int'(DA) : int'(DB);
        bad_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            pool[k] = 32'(((k * 37) % depth) * 4);
            d = $urandom;
            run_xact(sel, 1'b1, pool[k], d, 4'hF, lat, pu, e, rd, rh, pb);
            model_write(sel, pool[k], d, 4'hF);
        end
        for (int n = 0; n < nops; n++) begin
            case ($urandom_range(0, 9))
                0:       a = pool[$urandom_range(0, 15)] + 32'($urandom_range(1, 3));
                1:       a = 32'(4 * depth) + 32'(4 * $urandom_range(0, 255));
                default: a = pool[$urandom_range(0, 15)];
            endcase
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            b = 4'($urandom_range(0, 15));
            xe = is_bad(sel, a);
            xr = (w || xe) ? 32'h0 : model_read(sel, a);
            run_xact(sel, w, a, d, b, lat, pu, e, rd, rh, pb);
            if (w) model_write(sel, a, d, b);
            n_run++;
            if (lat !== wait_of(sel) || pu !== 1 || pb !== 0) begin
                n_fail++;
                bad_cnt++;
                $display("FAIL rand_timing[%0d/%0d]: addr=%h lat=%0d pulses=%0d proto=%0d want %0d/1/0",
                         sel, n, a, lat, pu, pb, wait_of(sel));
            end
            n_run++;
            if (e !== xe || rd !== xr || rh !== xr) begin
                n_fail++;
                bad_cnt++;
                $display("FAIL rand_data[%0d/%0d]: %s addr=%h be=%h err=%b rdata=%h hold=%h want %b/%h",
                         sel, n, w ? "wr" : "rd", a, b, e, rd, rh, xe, xr);
            end
            if (bad_cnt > 10) break;
        end
    endtask

    task automatic test_reset_abort();
        int lat, pu, pb, pulses;
        logic e;
        logic [31:0] rd, rh;
        logic [34:0] s;
        run_xact(0, 1'b1, 32'h20, 32'h0BADF00D, 4'hF, lat, pu, e, rd, rh, pb);
        model_write(0, 32'h20, 32'h0BADF00D, 4'hF);
        run_xact(0, 1'b0, 32'h20, 32'h0, 4'h0, lat, pu, e, rd, rh, pb);
        n_run++;
        if (rd !== 32'h0BADF00D) begin
            n_fail++;
            $display("FAIL abort_setup: rdata=%h want 0badf00d", rd);
        end
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h20, 32'h55AA55AA, 4'hF);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        #1;
        s = sample(0);
        n_run++;
        if (s !== 35'h0) begin
            n_fail++;
            $display("FAIL abort_async_clear: busy/ready/err=%b rdata=%h want 000/00000000", s[34:32], s[31:0]);
        end
        pulses = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            s = sample(0);
            if (s[33] !== 1'b0) pulses++;
        end
        @(negedge clk);
        rst_a = 1'b1;
        n_run++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL abort_no_ready: %0d ready cycles want 0", pulses);
        end
        run_xact(0, 1'b0, 32'h20, 32'h0, 4'h0, lat, pu, e, rd, rh, pb);
        n_run++;
        if (lat !== int'(WA) || rd !== 32'h0BADF00D || e !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_contents: lat=%0d rdata=%h err=%b want %0d/0badf00d/0", lat, rd, e, WA);
        end
    endtask

    initial begin
        n_run = 0;
        n_fail = 0;
        test_reset();
        test_basic();
        test_partial();
        test_errors();
        test_be_zero();
        test_hold_req(0, 32'h10);
        test_wait0();
        test_random(0, 40);
        test_random(1, 40);
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
